// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use and branch-flush control,
// multi-cycle MDU sequencing with selective stalling, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              ex_branch_taken,
    input  logic              id_mdu_start,
    input  logic              id_mfhilo,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              ctrl_sel,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } st_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

    st_t               st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_s;
    logic mstl_s;
    logic issue_s;

    // Hazard terms: a load writing $0 never creates a dependency.
    assign lu_s    = ex_memread && (ex_rt != {REG_W{1'b0}}) &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign mstl_s  = (st_q == ST_RUN) && (id_mdu_start || id_mfhilo);
    assign issue_s = id_mdu_start && !ex_branch_taken && !lu_s && (st_q != ST_RUN);

    // State register: FSM, MDU countdown and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            stall_cnt_q <= {PERF_W{1'b0}};
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic for the MDU sequencer.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            ST_IDLE: begin
                if (issue_s) begin
                    st_d  = ST_RUN;
                    cnt_d = CNT_LOAD;
                end else begin
                    st_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A taken branch does not abort the MDU; it keeps counting.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    st_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (issue_s) begin
                    st_d  = ST_RUN;
                    cnt_d = CNT_LOAD;
                end else begin
                    st_d  = ST_IDLE;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Pipeline control outputs: branch flush outranks both stall sources.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ctrl_sel   = 1'b1;
        ifid_flush = 1'b0;
        if (rst) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ctrl_sel   = 1'b1;
            ifid_flush = 1'b0;
        end else if (ex_branch_taken) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ctrl_sel   = 1'b0;
            ifid_flush = 1'b1;
        end else if (lu_s || mstl_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_sel   = 1'b0;
            ifid_flush = 1'b0;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ctrl_sel   = 1'b1;
            ifid_flush = 1'b0;
        end
        mdu_busy = !rst && (st_q == ST_RUN);
        mdu_done = !rst && (st_q == ST_DONE);
    end

    // Stall counter saturates at all-ones.
    always_comb begin
        if (!pc_write && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle-level reference model predicts every output,
// directed scenarios cover the key hazards, then randomized traffic runs against the model.
module tb_pipe_hazard_ctrl;

    localparam int MDU_LAT = 32;
    localparam int MAX16   = 65535;
    localparam int MAX4    = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
    logic       ex_memread = 1'b0, ex_branch_taken = 1'b0, id_mdu_start = 1'b0, id_mfhilo = 1'b0;

    logic        pc_write, ifid_write, ifid_flush, ctrl_sel, mdu_busy, mdu_done;
    logic [15:0] stall_cnt;
    logic        pc_write4, ifid_write4, ifid_flush4, ctrl_sel4, mdu_busy4, mdu_done4;
    logic [3:0]  stall_cnt4;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .id_mdu_start(id_mdu_start),
        .id_mfhilo(id_mfhilo), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .ctrl_sel(ctrl_sel), .mdu_busy(mdu_busy),
        .mdu_done(mdu_done), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.PERF_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .id_mdu_start(id_mdu_start),
        .id_mfhilo(id_mfhilo), .pc_write(pc_write4), .ifid_write(ifid_write4),
        .ifid_flush(ifid_flush4), .ctrl_sel(ctrl_sel4), .mdu_busy(mdu_busy4),
        .mdu_done(mdu_done4), .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pc, ifw, flush, ctrl, busy, done;
        int   sc16, sc4;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model: MDU as "cycles of busy left" plus a done flag.
    int   m_left = 0;
    bit   m_done = 1'b0;
    int   m_sc16 = 0;
    int   m_sc4  = 0;

    task automatic step(input logic r, input logic br, input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ms, input logic mf);
        exp_t e;
        bit   lu, busy, stl;
        @(posedge clk);
        #1;
        rst = r; ex_branch_taken = br; ex_memread = mr; ex_rt = ert;
        id_rs = rs; id_rt = rt; id_mdu_start = ms; id_mfhilo = mf;
        lu   = mr && (ert != 5'd0) && (ert == rs || ert == rt);
        busy = (m_left > 0);
        stl  = !r && !br && (lu || (busy && (ms || mf)));
        e.pc    = !stl;
        e.ifw   = !stl;
        e.ctrl  = r || (!br && !stl);
        e.flush = !r && br;
        e.busy  = !r && busy;
        e.done  = !r && m_done;
        e.sc16  = m_sc16;
        e.sc4   = m_sc4;
        sb_q.push_back(e);
        if (r) begin
            m_left = 0; m_done = 1'b0; m_sc16 = 0; m_sc4 = 0;
        end else begin
            if (stl) begin
                m_sc16 = (m_sc16 < MAX16) ? m_sc16 + 1 : MAX16;
                m_sc4  = (m_sc4 < MAX4) ? m_sc4 + 1 : MAX4;
            end
            if (busy) begin
                m_left = m_left - 1;
                m_done = (m_left == 0);
            end else begin
                m_done = 1'b0;
                if (ms && !br && !lu) m_left = MDU_LAT;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; pop and compare.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pc_write",   {31'd0, pc_write},   {31'd0, e.pc});
            chk("ifid_write", {31'd0, ifid_write}, {31'd0, e.ifw});
            chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, e.flush});
            chk("ctrl_sel",   {31'd0, ctrl_sel},   {31'd0, e.ctrl});
            chk("mdu_busy",   {31'd0, mdu_busy},   {31'd0, e.busy});
            chk("mdu_done",   {31'd0, mdu_done},   {31'd0, e.done});
            chk("stall_cnt",  {16'd0, stall_cnt},  32'(e.sc16));
            chk("stall_cnt4", {28'd0, stall_cnt4}, 32'(e.sc4));
            chk("pc_write4",  {31'd0, pc_write4},  {31'd0, e.pc});
            chk("mdu_done4",  {31'd0, mdu_done4},  {31'd0, e.done});
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, queue depth %0d, expected 0", sb_q.size());
        $fatal(1);
    end

    initial begin
        // Two reset edges bring the DUT out of its unknown power-up state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(2);
        // Load-use on rs, then on $0 (no stall), then branch overriding a load-use.
        step(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
        idle(1);
        // MDU issue, then HI/LO read held through RUN and release in DONE.
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < MDU_LAT + 2; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(2);
        // MDU issue, then a second MDU op held in ID issues back-to-back from DONE.
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < MDU_LAT + 2; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(MDU_LAT + 2);
        // MDU issue, then independent ALU ops (with a branch mid-RUN).
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < MDU_LAT + 2; i++)
            step(1'b0, (i == 5), 1'b0, 5'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'b0, 1'b0);
        // Reset at cycle 10 of RUN aborts the MDU.
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(9);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(MDU_LAT + 2);
        // Continuous load-use stalls drive the 4-bit counter into saturation.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0);
        idle(2);
        // Randomized traffic with small register ranges so hazards are frequent.
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        idle(1);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
